// File: rtl/qmult_pkg.sv
// rtl/qmult_pkg.sv - shared encodings, latency constant and range helpers for qmult_pipe
package qmult_pkg;

  typedef enum logic {
    ROUND_TRUNC   = 1'b0,
    ROUND_HALF_UP = 1'b1
  } round_mode_e;

  typedef enum logic {
    SAT_WRAP  = 1'b0,
    SAT_CLAMP = 1'b1
  } sat_mode_e;

  // Accepted-to-valid latency of qmult_pipe when not stalled.
  localparam int QMULT_LAT = 3;

  // Largest positive N-bit two's-complement value, zero-extended to 64 bits.
  function automatic logic [63:0] qmult_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Most negative N-bit two's-complement value, sign-extended to 64 bits.
  function automatic logic [63:0] qmult_min(input int n);
    return ~qmult_max(n);
  endfunction

endpackage

// File: rtl/qmult_round_sat.sv
// rtl/qmult_round_sat.sv - combinational round/shift and range check of a 2N-bit Q-format product
// Ports:
//   i_product  2N-bit signed product with 2Q fractional bits
//   i_round    rounding mode (truncate toward -inf, or round half up)
//   i_sat      overflow mode (wrap, or clamp to the N-bit range)
//   o_result   N-bit QI.Q result
//   o_ovr      rescaled product does not fit in N bits
module qmult_round_sat
  import qmult_pkg::*;
#(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic signed [2*N-1:0] i_product,
  input  round_mode_e           i_round,
  input  sat_mode_e             i_sat,
  output logic        [N-1:0]   o_result,
  output logic                  o_ovr
);

  localparam logic [63:0]  MAX64   = qmult_max(N);
  localparam logic [63:0]  MIN64   = qmult_min(N);
  localparam logic [N-1:0] SAT_POS = MAX64[N-1:0];
  localparam logic [N-1:0] SAT_NEG = MIN64[N-1:0];

  logic signed [2*N:0] rnd_add;
  logic signed [2*N:0] sum;
  logic signed [2*N:0] r;
  logic                fits;

  always_comb begin
    rnd_add = '0;
    if (i_round == ROUND_HALF_UP) begin
      rnd_add[Q-1] = 1'b1;
    end
    // One guard bit above the product so the rounding add cannot wrap.
    sum = {i_product[2*N-1], i_product} + rnd_add;
    r   = sum >>> Q;
    // R fits in N bits exactly when all bits from the N-bit sign position up agree.
    fits  = (&r[2*N:N-1]) | ~(|r[2*N:N-1]);
    o_ovr = ~fits;
    o_result = r[N-1:0];
    if (o_ovr && (i_sat == SAT_CLAMP)) begin
      o_result = r[2*N] ? SAT_NEG : SAT_POS;
    end
  end

endmodule

// File: rtl/qmult_pipe.sv
// rtl/qmult_pipe.sv - three-stage signed QI.Q multiplier with valid/ready flow control
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_valid / o_ready               operand handshake
//   i_multiplicand, i_multiplier    signed QI.Q operands
//   i_round, i_sat_en               per-operation rounding and saturation select
//   o_valid / i_ready               result handshake
//   o_result, o_ovr                 product and its overflow flag
//   o_ovr_sticky, i_ovr_clr         accumulated overflow flag and its clear
module qmult_pipe
  import qmult_pkg::*;
#(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_round,
  input  logic         i_sat_en,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_ovr,
  output logic         o_ovr_sticky,
  input  logic         i_ovr_clr
);

  // Whole pipeline advances together; it stalls only when the output is held.
  logic en;

  logic                s1_valid_q, s1_valid_d;
  logic [N-1:0]        a_q, a_d;
  logic [N-1:0]        b_q, b_d;
  round_mode_e         s1_round_q, s1_round_d;
  sat_mode_e           s1_sat_q, s1_sat_d;

  logic                s2_valid_q, s2_valid_d;
  logic signed [2*N-1:0] p_q, p_d;
  round_mode_e         s2_round_q, s2_round_d;
  sat_mode_e           s2_sat_q, s2_sat_d;

  logic                s3_valid_q, s3_valid_d;
  logic [N-1:0]        result_q, result_d;
  logic                ovr_q, ovr_d;
  logic                sticky_q, sticky_d;

  logic [N-1:0]        rs_result;
  logic                rs_ovr;

  qmult_round_sat #(
    .N(N),
    .Q(Q)
  ) u_round_sat (
    .i_product (p_q),
    .i_round   (s2_round_q),
    .i_sat     (s2_sat_q),
    .o_result  (rs_result),
    .o_ovr     (rs_ovr)
  );

  always_comb begin
    en = ~s3_valid_q | i_ready;

    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    s1_round_d = s1_round_q;
    s1_sat_d   = s1_sat_q;
    s2_valid_d = s2_valid_q;
    p_d        = p_q;
    s2_round_d = s2_round_q;
    s2_sat_d   = s2_sat_q;
    s3_valid_d = s3_valid_q;
    result_d   = result_q;
    ovr_d      = ovr_q;

    if (en) begin
      s1_valid_d = i_valid;
      a_d        = i_multiplicand;
      b_d        = i_multiplier;
      s1_round_d = round_mode_e'(i_round);
      s1_sat_d   = sat_mode_e'(i_sat_en);

      s2_valid_d = s1_valid_q;
      // Both operands sign-extended to 2N so the low 2N bits hold the exact signed product.
      p_d = $signed({{N{a_q[N-1]}}, a_q}) * $signed({{N{b_q[N-1]}}, b_q});
      s2_round_d = s1_round_q;
      s2_sat_d   = s1_sat_q;

      s3_valid_d = s2_valid_q;
      // Bubbles leave the last result in place rather than loading garbage.
      if (s2_valid_q) begin
        result_d = rs_result;
        ovr_d    = rs_ovr;
      end
    end

    // A set on an overflowing transfer wins over a clear in the same cycle.
    sticky_d = (sticky_q & ~i_ovr_clr) | (s3_valid_q & i_ready & ovr_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      s1_round_q <= ROUND_TRUNC;
      s1_sat_q   <= SAT_WRAP;
      s2_valid_q <= 1'b0;
      p_q        <= '0;
      s2_round_q <= ROUND_TRUNC;
      s2_sat_q   <= SAT_WRAP;
      s3_valid_q <= 1'b0;
      result_q   <= '0;
      ovr_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s1_round_q <= s1_round_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      p_q        <= p_d;
      s2_round_q <= s2_round_d;
      s2_sat_q   <= s2_sat_d;
      s3_valid_q <= s3_valid_d;
      result_q   <= result_d;
      ovr_q      <= ovr_d;
      sticky_q   <= sticky_d;
    end
  end

  assign o_ready      = en;
  assign o_valid      = s3_valid_q;
  assign o_result     = result_q;
  assign o_ovr        = ovr_q;
  assign o_ovr_sticky = sticky_q;

endmodule
